// File: rtl/seg_display_ctrl.sv
// Debug display controller: per-channel capture registers, manual/auto-scroll/freeze
// channel select and registered hex seven-segment decode. Optional: LEADING_ZERO_BLANK_EN.
module seg_display_ctrl #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DWELL_CYCLES = 50_000_000,
    localparam int unsigned SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned NUM_DIGITS  = DATA_W / 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    input  logic [NUM_CH-1:0]          ch_valid,
    input  logic [1:0]                 mode,
    input  logic [SEL_W-1:0]           manual_sel,
    output logic [NUM_DIGITS*7-1:0]    seg,
    output logic [SEL_W-1:0]           active_ch,
    output logic                       frozen
);

    localparam int unsigned CNT_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [1:0]  MODE_AUTO   = 2'b01;
    localparam logic [1:0]  MODE_FREEZE = 2'b10;

    logic [DATA_W-1:0]       cap_q [NUM_CH];
    logic [DATA_W-1:0]       cap_d [NUM_CH];
    logic [SEL_W-1:0]        active_q, active_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    frozen_q, frozen_d;
    logic [NUM_DIGITS*7-1:0] seg_q, seg_d;
    logic [DATA_W-1:0]       shown;
`ifdef LEADING_ZERO_BLANK_EN
    logic                    zero_above;
`endif

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Capture and channel-select next state; the dwell counter only runs in auto mode
    always_comb begin
        cap_d    = cap_q;
        active_d = active_q;
        cnt_d    = '0;
        frozen_d = (mode == MODE_FREEZE);

        if (mode != MODE_FREEZE) begin
            for (int k = 0; k < int'(NUM_CH); k++) begin
                if (ch_valid[k]) cap_d[k] = ch_data[k*DATA_W +: DATA_W];
            end
        end

        case (mode)
            MODE_FREEZE: active_d = active_q;
            MODE_AUTO: begin
                if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
                    active_d = (active_q == SEL_W'(NUM_CH - 1)) ? '0 : active_q + SEL_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                if ((SEL_W + 1)'(manual_sel) >= (SEL_W + 1)'(NUM_CH)) active_d = SEL_W'(NUM_CH - 1);
                else active_d = manual_sel;
            end
        endcase
    end

    // Hex decode of the channel selected by the registered active_ch
    always_comb begin
        seg_d = '1;
        shown = cap_q[active_q];
`ifdef LEADING_ZERO_BLANK_EN
        zero_above = 1'b1;
`endif
        for (int d = int'(NUM_DIGITS) - 1; d >= 0; d--) begin
            seg_d[d*7 +: 7] = hex7(shown[d*4 +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
            zero_above = zero_above && (shown[d*4 +: 4] == 4'h0);
            if (zero_above && (d != 0)) seg_d[d*7 +: 7] = 7'b1111111;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < int'(NUM_CH); k++) cap_q[k] <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            frozen_q <= 1'b0;
            seg_q    <= '1;
        end else begin
            cap_q    <= cap_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            frozen_q <= frozen_d;
            seg_q    <= seg_d;
        end
    end

    assign seg       = seg_q;
    assign active_ch = active_q;
    assign frozen    = frozen_q;

endmodule
